// File: rtl/opll_bus_pkg.sv
// opll_bus_pkg: shared types and default timing for the OPLL bus writer.
//   state_t    - writer FSM states (IDLE, address phase, data phase)
//   opll_req_t - one queued register write {addr, data}
//   DEF_*      - default FIFO depth and bus timing in clk cycles
package opll_bus_pkg;
    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, A_WAIT, D_SETUP, D_STROBE, D_HOLD, D_WAIT
    } state_t;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 2;
    localparam int DEF_ADDR_WAIT  = 12;
    localparam int DEF_DATA_WAIT  = 84;
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } opll_req_t;
endpackage

// File: rtl/opll_bus_if.sv
// opll_bus_if: valid/ready request port carrying one OPLL register write.
//   valid - request present (master -> slave)
//   ready - slave can accept (slave -> master)
//   addr  - OPLL register index
//   data  - value to write
interface opll_bus_if;
    logic       valid;
    logic       ready;
    logic [7:0] addr;
    logic [7:0] data;
    modport master (output valid, addr, data, input ready);
    modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/opll_req_fifo.sv
// opll_req_fifo: synchronous FIFO of opll_req_t with flush.
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, wdata  - enqueue (ignored when full or flushing)
//   pop, rdata   - dequeue; rdata shows the head entry
//   flush        - empty the FIFO this cycle, discarding any push
//   full, empty  - status
//   level        - number of queued entries
module opll_req_fifo
    import opll_bus_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  opll_req_t wdata,
    output opll_req_t rdata,
    output logic      full,
    output logic      empty,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    opll_req_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign rdata   = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= wdata;
    end
endmodule

// File: rtl/opll_bus_writer.sv
// opll_bus_writer: replays queued (register, value) requests as YM2413 address+data bus writes.
//   clk, rst_n  - clock (same as OPLL core), asynchronous active-low reset
//   req         - valid/ready request port (slave side)
//   flush       - drop queued requests not yet started
//   busy        - FSM active or requests queued
//   fifo_level  - queued entries
//   opll_din, opll_a0, opll_cs_n, opll_wr_n - registered OPLL CPU bus
module opll_bus_writer
    import opll_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int ADDR_WAIT  = DEF_ADDR_WAIT,
    parameter int DATA_WAIT  = DEF_DATA_WAIT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    opll_bus_if.slave                   req,
    input  logic                        flush,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  opll_din,
    output logic                        opll_a0,
    output logic                        opll_cs_n,
    output logic                        opll_wr_n
);
    localparam int M1   = SETUP_CYC > STROBE_CYC ? SETUP_CYC : STROBE_CYC;
    localparam int M2   = ADDR_WAIT > DATA_WAIT ? ADDR_WAIT : DATA_WAIT;
    localparam int MAXD = M1 > M2 ? M1 : M2;
    localparam int CW   = $clog2(MAXD + 1) > 7 ? $clog2(MAXD + 1) : 7;
    state_t state, st_n;
    logic [CW-1:0] cnt, cnt_n;
    opll_req_t head;
    logic [7:0] data_q;
    logic full, empty, pop;
    function automatic logic [CW-1:0] dur_m1(state_t s);
        return (s == A_SETUP || s == D_SETUP)   ? CW'(SETUP_CYC - 1)  :
               (s == A_STROBE || s == D_STROBE) ? CW'(STROBE_CYC - 1) :
               s == A_WAIT                      ? CW'(ADDR_WAIT - 1)  :
               s == D_WAIT                      ? CW'(DATA_WAIT - 1)  : '0;
    endfunction
    assign req.ready = !full;
    assign busy      = state != IDLE || !empty;
    opll_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req.valid && req.ready),
        .pop   (pop),
        .flush (flush),
        .wdata ('{addr: req.addr, data: req.data}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );
    // States run in enum order; each one lasts until the down-counter hits zero.
    always_comb begin
        st_n  = state;
        cnt_n = cnt - 1'b1;
        pop   = 1'b0;
        if (state == IDLE) begin
            cnt_n = '0;
            if (!empty && !flush) begin
                pop   = 1'b1;
                st_n  = A_SETUP;
                cnt_n = dur_m1(A_SETUP);
            end
        end else if (cnt == '0) begin
            st_n  = state == D_WAIT ? IDLE : state_t'(state + 1'b1);
            cnt_n = dur_m1(st_n);
        end
    end
    // Bus outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            data_q    <= '0;
            opll_din  <= '0;
            opll_a0   <= 1'b0;
            opll_cs_n <= 1'b1;
            opll_wr_n <= 1'b1;
        end else begin
            state     <= st_n;
            cnt       <= cnt_n;
            opll_cs_n <= !(st_n inside {A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD});
            opll_wr_n <= !(st_n inside {A_STROBE, D_STROBE});
            if (pop) begin
                data_q   <= head.data;
                opll_din <= head.addr;
                opll_a0  <= 1'b0;
            end else if (state == A_WAIT && st_n == D_SETUP) begin
                opll_din <= data_q;
                opll_a0  <= 1'b1;
            end
        end
    end
endmodule
